// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports and one
// write port. x0 is hard-wired to zero. A write in flight is forwarded to
// any read port addressing the same (non-zero) register in the same cycle.
// Storage is built from flops because reset must clear every entry at once.
`timescale 1ns/1ps
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  io_rf_ra1,
    input  logic [4:0]  io_rf_ra2,
    input  logic [4:0]  io_rf_wa,
    input  logic        io_rf_wen,
    input  logic [31:0] io_rf_wd,
    output logic [31:0] io_rf_rd1,
    output logic [31:0] io_rf_rd2
);

    // Current contents of every register, x0 tied to zero.
    logic [31:0] regs [32];

    // A write only counts when it targets a real register (not x0).
    logic wr_active;
    assign wr_active = io_rf_wen && (io_rf_wa != 5'd0);

    assign regs[0] = '0;

    // x1..x31: one register each, cleared asynchronously, loaded on a matching write.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] q_reg;

            // Hold the stored value; take write data when this entry is addressed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (io_rf_wen && (io_rf_wa == 5'(gi))) begin
                    q_reg <= io_rf_wd;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    // Port 1 read: stored value, overridden by the in-flight write on an address match.
    always_comb begin
        io_rf_rd1 = regs[io_rf_ra1];
        if (wr_active && (io_rf_ra1 == io_rf_wa)) begin
            io_rf_rd1 = io_rf_wd;
        end
    end

    // Port 2 read: same rule, independent of port 1.
    always_comb begin
        io_rf_rd2 = regs[io_rf_ra2];
        if (wr_active && (io_rf_ra2 == io_rf_wa)) begin
            io_rf_rd2 = io_rf_wd;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed check of reg_file against an array-based model.
`timescale 1ns/1ps
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic        wen;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference contents: plain array of register values.
    logic [31:0] model [32];

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_rf_ra1 (ra1),
        .io_rf_ra2 (ra2),
        .io_rf_wa  (wa),
        .io_rf_wen (wen),
        .io_rf_wd  (wd),
        .io_rf_rd1 (rd1),
        .io_rf_rd2 (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // What a read of address a should return given the current drive and model.
    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (wen && wa != 0 && a == wa) return wd;
        if (a == 0) return 32'h0;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One clock cycle: drive, check combinational reads mid-cycle, then take the edge.
    task automatic step(input logic rst_v, input logic wen_v, input logic [4:0] wa_v,
                        input logic [31:0] wd_v, input logic [4:0] ra1_v,
                        input logic [4:0] ra2_v, input string tag);
        rst_n = rst_v; wen = wen_v; wa = wa_v; wd = wd_v; ra1 = ra1_v; ra2 = ra2_v;
        if (!rst_v) clear_model();
        #2;
        check_value({tag, "_rd1"}, rd1, expect_read(ra1_v));
        check_value({tag, "_rd2"}, rd2, expect_read(ra2_v));
        $display("txn %0d %s rst_n=%b wen=%b wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
                 txn, tag, rst_v, wen_v, wa_v, wd_v, ra1_v, rd1, ra2_v, rd2);
        txn++;
        @(posedge clk);
        if (rst_v && wen_v && wa_v != 0) model[wa_v] = wd_v;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        clear_model();

        // Reads under reset, including bypass while reset is held.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd17, "in_reset");
        step(1'b0, 1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd8, "reset_bypass");
        // Write was suppressed in reset: x9 still zero after release.
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "post_reset");

        // Basic write/read and x0 rules.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, "wr_x5");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd_x5");
        step(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "wr_x0_bypass");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, "rd_x0");

        // Bypass then stored value without bypass.
        step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd6, "bypass_x7");
        step(1'b1, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7, "stored_x7");

        // Boundary registers and wen=0 hold.
        step(1'b1, 1'b1, 5'd1, 32'h00000001, 5'd0, 5'd0, "wr_x1");
        step(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd1, 5'd31, "wr_x31");
        step(1'b1, 1'b0, 5'd1, 32'h0, 5'd1, 5'd31, "hold_a");
        step(1'b1, 1'b0, 5'd31, 32'h0, 5'd1, 5'd31, "hold_b");

        // Fill x1..x31 with their index, then pulse reset between edges.
        for (int i = 1; i < 32; i++)
            step(1'b1, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), "fill");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd13, 5'd31, "filled");
        wen = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_value("pulse_low_rd1", rd1, 32'h0);
        check_value("pulse_low_rd2", rd2, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check_value("pulse_rel_rd1", rd1, 32'h0);
        check_value("pulse_rel_rd2", rd2, 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i), "after_pulse");

        // Random traffic with occasional reset cycles.
        for (int n = 0; n < 1200; n++) begin
            logic        r_rst;
            logic        r_wen;
            logic [4:0]  r_wa, r_ra1, r_ra2;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 99) != 0);
            r_wen = $urandom_range(0, 2) != 0;
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra2 = ($urandom_range(0, 3) == 0) ? r_ra1 : 5'($urandom_range(0, 31));
            step(r_rst, r_wen, r_wa, r_wd, r_ra1, r_ra2, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
